// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: request/response channel between one master and the data-memory arbiter
interface dm_arbiter_if;
    logic        valid;
    logic        ready;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output valid, we, size, addr, wdata, input ready, rvalid, rdata, err);
    modport slave  (input valid, we, size, addr, wdata, output ready, rvalid, rdata, err);
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-master round-robin arbiter and one-access sequencer for the data memory
module dm_arbiter #(
    parameter int DM_WORDS = 1024,
    parameter bit M0_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    dm_arbiter_if.slave m0,
    dm_arbiter_if.slave m1,
    output logic        dm_we_o,
    output logic [31:0] dm_addr_o,
    output logic [31:0] dm_wdata_o,
    output logic [1:0]  dm_wop_o,
    output logic [2:0]  dm_rop_o,
    input  logic [31:0] dm_rdata_i,
    output logic        busy_o
);
    localparam logic [32:0] LIMIT = 33'(DM_WORDS) * 33'd4;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q;
    logic        ptr_q, id_q, we_q, err_q;
    logic [1:0]  op_q, rv_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        gnt, go, req_we_d, req_err_d, v0, v1;
    logic [1:0]  req_size_d;
    logic [31:0] req_addr_d, req_wdata_d;

    // pick the winner (ptr_q breaks ties), raise its ready and judge its request
    always_comb begin
        gnt         = (m0.valid & m1.valid) ? ptr_q : m1.valid;
        go          = (state_q == IDLE) & ~reset & (m0.valid | m1.valid);
        m0.ready    = go & ~gnt;
        m1.ready    = go & gnt;
        req_we_d    = gnt ? m1.we    : m0.we;
        req_size_d  = gnt ? m1.size  : m0.size;
        req_addr_d  = gnt ? m1.addr  : m0.addr;
        req_wdata_d = gnt ? m1.wdata : m0.wdata;
        req_err_d   = (req_size_d == 2'd3)
                    | ((req_size_d == 2'd0) & (req_addr_d[1:0] != 2'd0))
                    | ((req_size_d == 2'd1) & req_addr_d[0])
                    | ({1'b0, req_addr_d} >= LIMIT);
    end

    // IDLE -> ACCESS -> RESP sequencer with holding and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= ~M0_FIRST;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= 2'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rv_q    <= 2'b00;
        end else begin
            case (state_q)
                IDLE: if (go) begin
                    id_q    <= gnt;
                    we_q    <= req_we_d;
                    err_q   <= req_err_d;
                    op_q    <= (req_size_d == 2'd3) ? 2'd0 : req_size_d;
                    addr_q  <= req_addr_d;
                    wdata_q <= req_wdata_d;
                    ptr_q   <= ~gnt;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    rdata_q <= (we_q | err_q) ? 32'd0 : dm_rdata_i;
                    rv_q    <= id_q ? 2'b10 : 2'b01;
                    state_q <= RESP;
                end
                RESP: begin
                    rv_q    <= 2'b00;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // memory strobes and per-master responses; reset gates anything still in flight
    always_comb begin
        dm_we_o    = (state_q == ACCESS) & we_q & ~err_q & ~reset;
        dm_addr_o  = addr_q;
        dm_wdata_o = wdata_q;
        dm_wop_o   = op_q;
        dm_rop_o   = {1'b0, op_q};
        busy_o     = state_q != IDLE;
        v0         = rv_q[0] & ~reset;
        v1         = rv_q[1] & ~reset;
        m0.rvalid  = v0;
        m0.err     = v0 & err_q;
        m0.rdata   = v0 ? rdata_q : 32'd0;
        m1.rvalid  = v1;
        m1.err     = v1 & err_q;
        m1.rdata   = v1 ? rdata_q : 32'd0;
    end
endmodule
